// File: rtl/tristate_pin_driver.sv
// Registered multi-channel pin driver with a bus-turnaround guard on newly driven pins.
// IDLE | accepting force vectors    TURN | newly enabled channels held Z, counting down
module tristate_pin_driver #(
  parameter int WIDTH       = 8,
  parameter int TURNAROUND  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VEC_VALID,
  output logic             VEC_READY,
  input  logic [WIDTH-1:0] VEC_DATA,
  input  logic [WIDTH-1:0] VEC_EN_BAR,
  inout  wire  [WIDTH-1:0] PIN,
  output logic [WIDTH-1:0] PIN_IN,
  output logic             BUSY
);

  localparam int CW = (TURNAROUND < 1) ? 1 : $clog2(TURNAROUND + 1);
  localparam logic [CW-1:0] CNT_INIT = (TURNAROUND == 0) ? '0 : CW'(TURNAROUND - 1);

  typedef enum logic [0:0] {IDLE, TURN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] en_bar_q, en_bar_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] new_mask;

  // Channels going from released to driven are the only ones that must wait.
  assign new_mask = ~VEC_EN_BAR & en_bar_q;

  always_comb begin
    state_d  = state_q;
    en_bar_d = en_bar_q;
    data_d   = data_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (VEC_VALID && ready_q) begin
          data_d = VEC_DATA;
          if ((new_mask != '0) && (TURNAROUND != 0)) begin
            en_bar_d = VEC_EN_BAR | new_mask;
            pend_d   = new_mask;
            cnt_d    = CNT_INIT;
            state_d  = TURN;
            ready_d  = 1'b0;
            busy_d   = 1'b1;
          end else begin
            en_bar_d = VEC_EN_BAR;
          end
        end
      end
      TURN: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (cnt_q == '0) begin
          en_bar_d = en_bar_q & ~pend_q;
          pend_d   = '0;
          state_d  = IDLE;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_d[0] = PIN;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      en_bar_q <= '1;
      data_q   <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      en_bar_q <= en_bar_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign PIN[i] = en_bar_q[i] ? 1'bz : data_q[i];
  end

  assign VEC_READY = ready_q;
  assign BUSY      = busy_q;
  assign PIN_IN    = sync_q[SYNC_STAGES-1];

endmodule
